// File: rtl/mc_arb_pkg.sv
// Shared types and constants for the DDR2 command-port arbiter.
// Build option MC_ARB_FIXED_PRIO_EN is consumed by rr_arb2.
package mc_arb_pkg;

    localparam int DEF_DATA_W = 256;
    localparam int DEF_ADDR_W = 28;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant picker: round-robin by default, or data-cache-first
// when MC_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
    import mc_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       winner,
    output logic       any_req
);

    assign any_req = |req;

`ifdef MC_ARB_FIXED_PRIO_EN
    logic unused_prio;
    assign unused_prio = prio;

    assign winner = req[PORT1] ? PORT1 : PORT0;
`else
    always_comb begin
        winner = PORT0;
        if (req[PORT0] && req[PORT1])
            winner = prio;
        else if (req[PORT1])
            winner = PORT1;
    end
`endif

endmodule

// File: rtl/mc_port_arbiter.sv
// Shares the single DDR2 MC command port between I-cache (port 0) and D-cache (port 1).
// Build option MC_ARB_FIXED_PRIO_EN makes port 1 win every simultaneous request.
module mc_port_arbiter
    import mc_arb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [DATA_W-1:0] mem_data_wr0,
    input  logic [ADDR_W-1:0] mem_data_addr0,
    input  logic              mem_rw_data0,
    input  logic              mem_valid_data0,
    output logic [DATA_W-1:0] mem_data_rd0,
    output logic              mem_ready_data0,

    input  logic [DATA_W-1:0] mem_data_wr1,
    input  logic [ADDR_W-1:0] mem_data_addr1,
    input  logic              mem_rw_data1,
    input  logic              mem_valid_data1,
    output logic [DATA_W-1:0] mem_data_rd1,
    output logic              mem_ready_data1,

    output logic [DATA_W-1:0] mc_data_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic              mc_rw,
    output logic              mc_valid,
    input  logic [DATA_W-1:0] mc_data_rd,
    input  logic              mc_ready,

    output logic              busy,
    output logic              error
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    logic             prio;
    logic [CNT_W-1:0] wait_cnt;
    logic             winner;
    logic             any_req;
    logic             expire;

    rr_arb2 u_pick (
        .req     ({mem_valid_data1, mem_valid_data0}),
        .prio    (prio),
        .winner  (winner),
        .any_req (any_req)
    );

    // The last waiting cycle of a grant; a simultaneous mc_ready still wins.
    assign expire = (wait_cnt == CNT_LAST);

    // Returning to IDLE after every command gives the one-cycle mc_valid bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= PORT0;
            wait_cnt <= '0;
            error    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (any_req) begin
                        state <= (winner == PORT1) ? GNT1 : GNT0;
                        busy  <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (mc_ready || expire) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        prio  <= (state == GNT0) ? PORT1 : PORT0;
                        if (!mc_ready)
                            error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mc_data_wr = '0;
        mc_addr    = '0;
        mc_rw      = 1'b0;
        mc_valid   = 1'b0;
        case (state)
            GNT0: begin
                mc_data_wr = mem_data_wr0;
                mc_addr    = mem_data_addr0;
                mc_rw      = mem_rw_data0;
                mc_valid   = 1'b1;
            end
            GNT1: begin
                mc_data_wr = mem_data_wr1;
                mc_addr    = mem_data_addr1;
                mc_rw      = mem_rw_data1;
                mc_valid   = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_ready_data0 = (state == GNT0) && mc_ready;
    assign mem_ready_data1 = (state == GNT1) && mc_ready;

    assign mem_data_rd0 = mc_data_rd;
    assign mem_data_rd1 = mc_data_rd;

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed self-checking bench for mc_port_arbiter (TIMEOUT shortened to 8).
module tb_mc_port_arbiter;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 28;
    localparam int TIMEOUT = 8;

    localparam logic [DATA_W-1:0] WDATA0 = {8{32'hA5A5_0001}};
    localparam logic [DATA_W-1:0] WDATA1 = {8{32'h5A5A_0002}};
    localparam logic [DATA_W-1:0] RDATA  =
        256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
    localparam logic [ADDR_W-1:0] ADDR0  = 28'h0001000;
    localparam logic [ADDR_W-1:0] ADDR1  = 28'h3001040;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] mem_data_wr0, mem_data_wr1;
    logic [ADDR_W-1:0] mem_data_addr0, mem_data_addr1;
    logic              mem_rw_data0, mem_rw_data1;
    logic              mem_valid_data0, mem_valid_data1;
    logic [DATA_W-1:0] mem_data_rd0, mem_data_rd1;
    logic              mem_ready_data0, mem_ready_data1;
    logic [DATA_W-1:0] mc_data_wr;
    logic [ADDR_W-1:0] mc_addr;
    logic              mc_rw, mc_valid;
    logic [DATA_W-1:0] mc_data_rd;
    logic              mc_ready;
    logic              busy, error;

    int total = 0;
    int bad   = 0;
    int pulses0, pulses1;
    int exp_port;

    always #5 clk = ~clk;

    mc_port_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_data_wr0    (mem_data_wr0),
        .mem_data_addr0  (mem_data_addr0),
        .mem_rw_data0    (mem_rw_data0),
        .mem_valid_data0 (mem_valid_data0),
        .mem_data_rd0    (mem_data_rd0),
        .mem_ready_data0 (mem_ready_data0),
        .mem_data_wr1    (mem_data_wr1),
        .mem_data_addr1  (mem_data_addr1),
        .mem_rw_data1    (mem_rw_data1),
        .mem_valid_data1 (mem_valid_data1),
        .mem_data_rd1    (mem_data_rd1),
        .mem_ready_data1 (mem_ready_data1),
        .mc_data_wr      (mc_data_wr),
        .mc_addr         (mc_addr),
        .mc_rw           (mc_rw),
        .mc_valid        (mc_valid),
        .mc_data_rd      (mc_data_rd),
        .mc_ready        (mc_ready),
        .busy            (busy),
        .error           (error)
    );

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                               input logic [DATA_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic valid, input logic rw,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        if (port == 0) begin
            mem_valid_data0 = valid;
            mem_rw_data0    = rw;
            mem_data_addr0  = addr;
            mem_data_wr0    = data;
        end else begin
            mem_valid_data1 = valid;
            mem_rw_data1    = rw;
            mem_data_addr1  = addr;
            mem_data_wr1    = data;
        end
    endtask

    task automatic applyReset();
        rst        = 1'b1;
        mc_ready   = 1'b0;
        mc_data_rd = '0;
        applyStimulus(0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1, 1'b0, 1'b0, '0, '0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Port 0 write alone, MC answers on the third grant cycle
        $display("[TB] port 0 single write");
        applyReset();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mc_valid", mc_valid, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_mc_addr", mc_addr, 0);
        checkOutput("rst_ready0", mem_ready_data0, 0);
        checkOutput("rst_ready1", mem_ready_data1, 0);

        applyStimulus(0, 1'b1, 1'b1, ADDR0, WDATA0);
        #1;
        checkOutput("t1_valid_at_t", mc_valid, 0);
        pulses0 = 0;
        pulses1 = 0;
        nextCycle();
        checkOutput("t1_valid_t1", mc_valid, 1);
        checkOutput("t1_rw", mc_rw, 1);
        checkOutput("t1_addr", mc_addr, ADDR0);
        checkOutput("t1_wdata", mc_data_wr, WDATA0);
        checkOutput("t1_busy", busy, 1);
        pulses0 += mem_ready_data0;
        pulses1 += mem_ready_data1;
        nextCycle();
        pulses0 += mem_ready_data0;
        pulses1 += mem_ready_data1;
        nextCycle();
        mc_ready = 1'b1;
        #1;
        checkOutput("t1_ready0", mem_ready_data0, 1);
        pulses0 += mem_ready_data0;
        pulses1 += mem_ready_data1;
        nextCycle();
        mc_ready = 1'b0;
        applyStimulus(0, 1'b0, 1'b1, ADDR0, WDATA0);
        #1;
        checkOutput("t1_bubble", mc_valid, 0);
        checkOutput("t1_busy_done", busy, 0);
        pulses0 += mem_ready_data0;
        pulses1 += mem_ready_data1;
        checkOutput("t1_pulses0", pulses0, 1);
        checkOutput("t1_pulses1", pulses1, 0);

        // Both ports requesting continuously, two-cycle commands
        $display("[TB] both ports contending");
        applyReset();
        applyStimulus(0, 1'b1, 1'b1, ADDR0, WDATA0);
        applyStimulus(1, 1'b1, 1'b0, ADDR1, WDATA1);
        pulses0 = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef MC_ARB_FIXED_PRIO_EN
            exp_port = 1;
`else
            exp_port = k % 2;
`endif
            nextCycle();
            checkOutput($sformatf("t2_valid_%0d", k), mc_valid, 1);
            checkOutput($sformatf("t2_addr_%0d", k), mc_addr, (exp_port == 1) ? ADDR1 : ADDR0);
            nextCycle();
            mc_ready = 1'b1;
            #1;
            checkOutput($sformatf("t2_rdy0_%0d", k), mem_ready_data0, (exp_port == 0) ? 1 : 0);
            checkOutput($sformatf("t2_rdy1_%0d", k), mem_ready_data1, (exp_port == 1) ? 1 : 0);
            pulses0 += mem_ready_data0;
            nextCycle();
            mc_ready = 1'b0;
            #1;
            checkOutput($sformatf("t2_bubble_%0d", k), mc_valid, 0);
        end
`ifdef MC_ARB_FIXED_PRIO_EN
        checkOutput("t2_port0_grants", pulses0, 0);
`else
        checkOutput("t2_port0_grants", pulses0, 2);
`endif

        // Port 1 read with combinational read-data return
        $display("[TB] port 1 read");
        applyReset();
        applyStimulus(1, 1'b1, 1'b0, ADDR1, WDATA1);
        nextCycle();
        checkOutput("t4_addr", mc_addr, ADDR1);
        checkOutput("t4_rw", mc_rw, 0);
        mc_data_rd = RDATA;
        mc_ready   = 1'b1;
        #1;
        checkOutput("t4_rd1", mem_data_rd1, RDATA);
        checkOutput("t4_rd0", mem_data_rd0, RDATA);
        checkOutput("t4_ready1", mem_ready_data1, 1);
        checkOutput("t4_ready0", mem_ready_data0, 0);
        nextCycle();
        mc_ready = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, ADDR1, WDATA1);

        // MC never answers: error after 8 grant cycles, arbitration continues
        $display("[TB] timeout");
        applyReset();
        applyStimulus(0, 1'b1, 1'b1, ADDR0, WDATA0);
        pulses0 = 0;
        pulses1 = 0;
        nextCycle();
        for (int g = 1; g <= TIMEOUT; g++) begin
            checkOutput($sformatf("t5_valid_g%0d", g), mc_valid, 1);
            checkOutput($sformatf("t5_noerr_g%0d", g), error, 0);
            pulses0 += mem_ready_data0;
            pulses1 += mem_ready_data1;
            nextCycle();
        end
        checkOutput("t5_error", error, 1);
        checkOutput("t5_idle_valid", mc_valid, 0);
        checkOutput("t5_idle_busy", busy, 0);
        checkOutput("t5_no_pulse", pulses0 + pulses1, 0);
        applyStimulus(1, 1'b1, 1'b0, ADDR1, WDATA1);
        nextCycle();
        checkOutput("t5_regrant_valid", mc_valid, 1);
        checkOutput("t5_regrant_addr", mc_addr, ADDR1);
        mc_ready = 1'b1;
        #1;
        checkOutput("t5_regrant_ready1", mem_ready_data1, 1);
        nextCycle();
        mc_ready = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, ADDR0, WDATA0);
        applyStimulus(1, 1'b0, 1'b0, ADDR1, WDATA1);
        #1;
        checkOutput("t5_error_sticky", error, 1);

        // mc_ready on the expiry cycle is a normal completion
        $display("[TB] ready at expiry");
        applyReset();
        applyStimulus(0, 1'b1, 1'b1, ADDR0, WDATA0);
        nextCycle();
        for (int g = 2; g <= TIMEOUT; g++) nextCycle();
        mc_ready = 1'b1;
        #1;
        checkOutput("t5b_ready0", mem_ready_data0, 1);
        nextCycle();
        mc_ready = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, ADDR0, WDATA0);
        #1;
        checkOutput("t5b_no_error", error, 0);

        // Reset in the middle of a grant, then a late mc_ready
        $display("[TB] reset mid-grant");
        applyReset();
        applyStimulus(0, 1'b1, 1'b1, ADDR0, WDATA0);
        nextCycle();
        checkOutput("t6_granted", mc_valid, 1);
        rst = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, ADDR0, WDATA0);
        #1;
        checkOutput("t6_valid_async", mc_valid, 0);
        checkOutput("t6_busy_async", busy, 0);
        checkOutput("t6_addr_async", mc_addr, 0);
        mc_ready = 1'b1;
        #1;
        checkOutput("t6_rdy0_in_rst", mem_ready_data0, 0);
        checkOutput("t6_rdy1_in_rst", mem_ready_data1, 0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("t6_rdy0_late", mem_ready_data0, 0);
        checkOutput("t6_rdy1_late", mem_ready_data1, 0);
        nextCycle();
        checkOutput("t6_idle_valid", mc_valid, 0);
        checkOutput("t6_error", error, 0);
        mc_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
